// File: rtl/operand_collect.sv
// ---------------------------------------------------------------------------
// operand_collect
//
// Operand-collect stage between issue and execute. It sits directly
// downstream of the integer register file. The stage drives the register
// file read addresses and consumes the registered rdata one cycle later.
//
// It also snoops both register-file write ports so that every presented
// operand is architecturally current. Two cases need this:
//   - a write landing on the same edge the register file samples its read
//     data (the register file returns the old value), and
//   - writes that land while the stage is stalled (rdata is frozen).
// In both cases the written value is captured into a per-operand override
// register, and that register is used instead of rdata.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   stall, flush          hold this stage / kill the held instruction
//   in_valid, in_rs0/1,   incoming instruction and its sideband tag (PC)
//   in_tag
//   in_ready              combinational !stall
//   raddr0/1              register file read addresses (= in_rs0/1)
//   rdata0/1              registered register file read data
//   wen*/waddr*/wdata*    snoop of register file write ports (port 1 wins)
//   out_valid, out_rs0/1, operand bundle presented to execute
//   out_op0/1, out_tag
//   ovr0/1                debug: operand comes from an override register
// ---------------------------------------------------------------------------
module operand_collect #(
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [4:0]       in_rs0,
  input  logic [4:0]       in_rs1,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic [4:0]       raddr0,
  output logic [4:0]       raddr1,
  input  logic [31:0]      rdata0,
  input  logic [31:0]      rdata1,
  input  logic             wen0,
  input  logic [4:0]       waddr0,
  input  logic [31:0]      wdata0,
  input  logic             wen1,
  input  logic [4:0]       waddr1,
  input  logic [31:0]      wdata1,
  output logic             out_valid,
  output logic [4:0]       out_rs0,
  output logic [4:0]       out_rs1,
  output logic [31:0]      out_op0,
  output logic [31:0]      out_op1,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovr0,
  output logic             ovr1
);

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } snoop_t;

  // Write-port snoop for one register address. r0 never matches, so it can
  // never be overridden. Port 1 is checked first because it has priority.
  function automatic snoop_t snoop(input logic [4:0] a,
                                   input logic we0, input logic [4:0] wa0,
                                   input logic [31:0] wd0,
                                   input logic we1, input logic [4:0] wa1,
                                   input logic [31:0] wd1);
    snoop_t s;
    s.hit  = 1'b0;
    s.data = '0;
    if (a != 5'd0) begin
      if (we1 && (wa1 == a)) begin
        s.hit  = 1'b1;
        s.data = wd1;
      end else if (we0 && (wa0 == a)) begin
        s.hit  = 1'b1;
        s.data = wd0;
      end
    end
    return s;
  endfunction

  // Stage registers. Index 0/1 selects the operand.
  logic             valid_q, valid_d;
  logic [1:0][4:0]  rs_q,    rs_d;
  logic [TAG_W-1:0] tag_q,   tag_d;
  logic [1:0]       ovr_q,   ovr_d;
  logic [1:0][31:0] val_q,   val_d;

  logic [1:0][4:0]  cmp_addr;
  snoop_t [1:0]     sn;

  assign in_ready = !stall;
  assign raddr0   = in_rs0;
  assign raddr1   = in_rs1;

  // On a load edge the snoop compares against the incoming sources (the
  // register file samples those same addresses at this edge). While stalled
  // it compares against the held sources.
  always_comb begin
    cmp_addr[0] = stall ? rs_q[0] : in_rs0;
    cmp_addr[1] = stall ? rs_q[1] : in_rs1;
    for (int k = 0; k < 2; k++) begin
      sn[k] = snoop(cmp_addr[k], wen0, waddr0, wdata0, wen1, waddr1, wdata1);
    end
  end

  // NOTE: every always_comb output gets a default (hold value) before any
  // branch, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    rs_d    = rs_q;
    tag_d   = tag_q;
    ovr_d   = ovr_q;
    val_d   = val_q;

    if (flush) begin
      // Flush beats stall; the incoming instruction is dropped.
      valid_d = 1'b0;
      ovr_d   = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      rs_d[0] = in_rs0;
      rs_d[1] = in_rs1;
      tag_d   = in_tag;
      for (int k = 0; k < 2; k++) begin
        ovr_d[k] = sn[k].hit;
        if (sn[k].hit) val_d[k] = sn[k].data;
      end
    end else begin
      // A stalled hit replaces any older override. A miss keeps what is held.
      for (int k = 0; k < 2; k++) begin
        if (sn[k].hit) begin
          ovr_d[k] = 1'b1;
          val_d[k] = sn[k].data;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      tag_q   <= '0;
      ovr_q   <= '0;
      val_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rs_q    <= rs_d;
      tag_q   <= tag_d;
      ovr_q   <= ovr_d;
      val_q   <= val_d;
    end
  end

  assign out_valid = valid_q;
  assign out_rs0   = rs_q[0];
  assign out_rs1   = rs_q[1];
  assign out_tag   = tag_q;
  assign ovr0      = ovr_q[0];
  assign ovr1      = ovr_q[1];

  assign out_op0 = (!valid_q || rs_q[0] == 5'd0) ? 32'd0 :
                   (ovr_q[0] ? val_q[0] : rdata0);
  assign out_op1 = (!valid_q || rs_q[1] == 5'd0) ? 32'd0 :
                   (ovr_q[1] ? val_q[1] : rdata1);

endmodule

// File: tb/tb_operand_collect.sv
// ---------------------------------------------------------------------------
// tb_operand_collect
//
// Includes a behavioural register file (registered reads that hold on
// stall). A scoreboard is fed from an architectural model:
//   - expected operand = current architectural value of the register;
//   - expected override flag = "the register was written at or after the
//     edge on which the register file sampled it, with no flush since".
// A monitor on the falling edge pops one expected bundle per cycle and
// compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_operand_collect;

  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             rst, stall, flush, in_valid;
  logic [4:0]       in_rs0, in_rs1;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready;
  logic [4:0]       raddr0, raddr1;
  logic [31:0]      rdata0, rdata1;
  logic             wen0, wen1;
  logic [4:0]       waddr0, waddr1;
  logic [31:0]      wdata0, wdata1;
  logic             out_valid;
  logic [4:0]       out_rs0, out_rs1;
  logic [31:0]      out_op0, out_op1;
  logic [TAG_W-1:0] out_tag;
  logic             ovr0, ovr1;

  operand_collect #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rs0(in_rs0), .in_rs1(in_rs1), .in_tag(in_tag),
    .in_ready(in_ready), .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(rdata0), .rdata1(rdata1),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .out_valid(out_valid), .out_rs0(out_rs0), .out_rs1(out_rs1),
    .out_op0(out_op0), .out_op1(out_op1), .out_tag(out_tag),
    .ovr0(ovr0), .ovr1(ovr1)
  );

  always #5 clk = ~clk;

  // Register file environment: reads registered and held on stall. Writes
  // are not visible to a read on the same edge; port 1 is applied last.
  logic [31:0] rf [32];
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rdata0 = '0;
    rdata1 = '0;
  end
  always @(posedge clk) begin
    if (!stall) begin
      rdata0 <= rf[raddr0];
      rdata1 <= rf[raddr1];
    end
    if (wen0) rf[waddr0] <= wdata0;
    if (wen1) rf[waddr1] <= wdata1;
  end

  typedef struct {
    logic        v, stall, flush, rst, we0, we1;
    logic [4:0]  rs0, rs1, wa0, wa1;
    logic [31:0] tag, wd0, wd1;
  } stim_t;

  typedef struct {
    logic        valid, ovr0, ovr1;
    logic [4:0]  rs0, rs1;
    logic [31:0] tag, op0, op1;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Architectural model state.
  logic [31:0] arch [32];
  logic        m_valid, m_ovr0, m_ovr1;
  logic [4:0]  m_rs0, m_rs1;
  logic [31:0] m_tag;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.v = 0; s.stall = 0; s.flush = 0; s.rst = 0; s.we0 = 0; s.we1 = 0;
    s.rs0 = 0; s.rs1 = 0; s.wa0 = 0; s.wa1 = 0;
    s.tag = 0; s.wd0 = 0; s.wd1 = 0;
    return s;
  endfunction

  function automatic logic written(input stim_t s, input logic [4:0] a);
    return (a != 5'd0) && ((s.we0 && s.wa0 == a) || (s.we1 && s.wa1 == a));
  endfunction

  // Drive one cycle, let the edge happen, advance the model, push expected.
  task automatic step(input stim_t s);
    exp_t e;
    rst = s.rst; stall = s.stall; flush = s.flush; in_valid = s.v;
    in_rs0 = s.rs0; in_rs1 = s.rs1; in_tag = s.tag;
    wen0 = s.we0; waddr0 = s.wa0; wdata0 = s.wd0;
    wen1 = s.we1; waddr1 = s.wa1; wdata1 = s.wd1;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, !s.stall});
    check("raddr0", {27'd0, raddr0}, {27'd0, s.rs0});
    check("raddr1", {27'd0, raddr1}, {27'd0, s.rs1});
    @(posedge clk);
    if (s.rst) begin
      m_valid = 0; m_rs0 = 0; m_rs1 = 0; m_tag = 0; m_ovr0 = 0; m_ovr1 = 0;
    end else if (s.flush) begin
      m_valid = 0; m_ovr0 = 0; m_ovr1 = 0;
    end else if (!s.stall) begin
      m_valid = s.v; m_rs0 = s.rs0; m_rs1 = s.rs1; m_tag = s.tag;
      m_ovr0 = written(s, s.rs0);
      m_ovr1 = written(s, s.rs1);
    end else begin
      m_ovr0 = m_ovr0 | written(s, m_rs0);
      m_ovr1 = m_ovr1 | written(s, m_rs1);
    end
    if (s.we0) arch[s.wa0] = s.wd0;
    if (s.we1) arch[s.wa1] = s.wd1;
    e.valid = m_valid; e.rs0 = m_rs0; e.rs1 = m_rs1; e.tag = m_tag;
    e.ovr0 = m_ovr0; e.ovr1 = m_ovr1;
    e.op0 = (m_valid && m_rs0 != 0) ? arch[m_rs0] : 32'd0;
    e.op1 = (m_valid && m_rs1 != 0) ? arch[m_rs1] : 32'd0;
    sb_q.push_back(e);
    #1;
  endtask

  // Monitor: one expected bundle per cycle, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_valid", {31'd0, out_valid}, {31'd0, e.valid});
        check("sb_rs0", {27'd0, out_rs0}, {27'd0, e.rs0});
        check("sb_rs1", {27'd0, out_rs1}, {27'd0, e.rs1});
        check("sb_tag", out_tag, e.tag);
        check("sb_op0", out_op0, e.op0);
        check("sb_op1", out_op1, e.op1);
        check("sb_ovr0", {31'd0, ovr0}, {31'd0, e.ovr0});
        check("sb_ovr1", {31'd0, ovr1}, {31'd0, e.ovr1});
      end
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 32; i++) arch[i] = '0;
    m_valid = 0; m_rs0 = 0; m_rs1 = 0; m_tag = 0; m_ovr0 = 0; m_ovr1 = 0;

    // Reset state.
    s = idle(); s.rst = 1;
    step(s);
    step(s);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_tag", out_tag, 32'd0);

    // Preload r5 and r3 through the write ports.
    s = idle(); s.we0 = 1; s.wa0 = 5; s.wd0 = 32'h1111_2222;
    s.we1 = 1; s.wa1 = 3; s.wd1 = 32'h0000_0010;
    step(s);

    // Plain read.
    s = idle(); s.v = 1; s.rs0 = 5; s.rs1 = 0; s.tag = 32'h40;
    step(s);
    check("plain_valid", {31'd0, out_valid}, 32'd1);
    check("plain_op0", out_op0, 32'h1111_2222);
    check("plain_op1", out_op1, 32'd0);
    check("plain_ovr0", {31'd0, ovr0}, 32'd0);
    check("plain_tag", out_tag, 32'h40);

    // Write coincident with the read edge.
    s = idle(); s.v = 1; s.rs0 = 7; s.we0 = 1; s.wa0 = 7; s.wd0 = 32'hAAAA_0001;
    step(s);
    check("coinc_op0", out_op0, 32'hAAAA_0001);
    check("coinc_ovr0", {31'd0, ovr0}, 32'd1);

    // Both ports hit the same register: port 1 wins.
    s = idle(); s.v = 1; s.rs1 = 9; s.we0 = 1; s.wa0 = 9; s.wd0 = 32'h1;
    s.we1 = 1; s.wa1 = 9; s.wd1 = 32'h2;
    step(s);
    check("prio_op1", out_op1, 32'h2);

    // Stall snoop on r3.
    s = idle(); s.v = 1; s.rs0 = 3; s.tag = 32'h80;
    step(s);
    check("stall_load_op0", out_op0, 32'h10);
    s = idle(); s.stall = 1; s.we0 = 1; s.wa0 = 3; s.wd0 = 32'h20;
    step(s);
    check("stall_c1_op0", out_op0, 32'h20);
    s = idle(); s.stall = 1; s.we1 = 1; s.wa1 = 3; s.wd1 = 32'h30;
    step(s);
    check("stall_c2_op0", out_op0, 32'h30);
    s = idle(); s.stall = 1;
    step(s);
    check("stall_c3_op0", out_op0, 32'h30);
    check("stall_tag", out_tag, 32'h80);

    // Release into a load with rs0 == rs1 == 3.
    s = idle(); s.v = 1; s.rs0 = 3; s.rs1 = 3;
    step(s);
    check("same_op0", out_op0, 32'h30);
    check("same_op1", out_op1, 32'h30);

    // r0 guard.
    s = idle(); s.v = 1; s.rs0 = 0; s.we0 = 1; s.wa0 = 0; s.wd0 = 32'hFFFF_FFFF;
    step(s);
    check("r0_op0", out_op0, 32'd0);
    check("r0_ovr0", {31'd0, ovr0}, 32'd0);

    // Flush beats stall, incoming instruction dropped.
    s = idle(); s.v = 1; s.rs0 = 5; s.rs1 = 3; s.stall = 1; s.flush = 1;
    step(s);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_op0", out_op0, 32'd0);
    check("flush_op1", out_op1, 32'd0);

    // Reset in the middle of a stall.
    s = idle(); s.v = 1; s.rs0 = 5; s.rs1 = 7; s.tag = 32'h99;
    step(s);
    s = idle(); s.stall = 1; s.we0 = 1; s.wa0 = 5; s.wd0 = 32'h55;
    step(s);
    s = idle(); s.stall = 1; s.rst = 1;
    step(s);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_rs0", {27'd0, out_rs0}, 32'd0);
    check("rst_mid_ovr0", {31'd0, ovr0}, 32'd0);
    check("rst_mid_op0", out_op0, 32'd0);

    // Randomized traffic on a small register window to force collisions.
    for (int n = 0; n < 800; n++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 59) == 0);
      s.flush = ($urandom_range(0, 11) == 0);
      s.stall = ($urandom_range(0, 2) == 0);
      s.v     = ($urandom_range(0, 3) != 0);
      s.rs0   = 5'($urandom_range(0, 7));
      s.rs1   = 5'($urandom_range(0, 7));
      s.tag   = $urandom;
      s.we0   = $urandom_range(0, 1);
      s.wa0   = 5'($urandom_range(0, 7));
      s.wd0   = $urandom;
      s.we1   = $urandom_range(0, 1);
      s.wa1   = 5'($urandom_range(0, 7));
      s.wd1   = $urandom;
      step(s);
    end

    // Bounded drain of the scoreboard.
    for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(negedge clk);
    #1;
    check("sb_drain", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
